ksa_ctrl_fsm: RTL
=================

Name: ksa_ctrl_fsm

Overview:
- RC4 key-scheduling (KSA) loop controller; sits directly upstream of the swap FSM.
- For i = 0..255, reads s[i] from the shared S working memory and computes j = j + s[i] + key[i mod KEY_LEN].
- Presents i and j to the swap FSM, raises the swap request and waits for the swap to complete.
- Runs once the S-memory init pass (s[i]=i) is finished; its done pulse hands off to the PRGA stage.

Parameters:
- KEY_LEN, 3, key length in bytes.
- KEY_W, 24, secret key width in bits; must equal 8*KEY_LEN.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a KSA pass; sampled only in IDLE.
- secret_key  input  KEY_W  key; byte k = secret_key[KEY_W-1-8k -: 8] (byte 0 is MSB).
- s_q  input  8  S-memory read data.
- s_addr  output  8  S-memory address while this block owns the bus.
- counter_i  output  8  current i, to the swap FSM.
- counter_j  output  8  current j, to the swap FSM.
- swap_flag  output  1  swap request to the swap FSM.
- swap_done  input  1  swap complete, from the swap FSM.
- bus_own  output  1  1 = top-level mux routes s_addr to memory; 0 = swap FSM owns the address.
- wren  output  1  always 0; this block never writes.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the pass completes.

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE; counter_i=0; counter_j=0; s_addr=0; swap_flag=0; bus_own=1; busy=0; done=0; wren=0; internal s_i=0.
- Reset mid-pass aborts the pass immediately; swap_flag drops the next cycle. The top level also resets the swap FSM.
- Memory model: s_addr registered, synchronous RAM; s_q is valid two cycles after s_addr is updated.
- IDLE: on start -> RD_I, clear i and j to 0. start is ignored in every other state.
- RD_I: s_addr<=counter_i, bus_own<=1 -> WAIT.
- WAIT: -> CAPT.
- CAPT: s_i<=s_q -> CALC.
- CALC: counter_j <= counter_j + s_i + key[counter_i mod KEY_LEN], 8-bit modulo-256 sum -> REQ.
  - Key index: a 2-bit counter k that wraps at KEY_LEN-1; no divider.
- REQ, on entry: swap_flag<=1, bus_own<=0.
  - Holds while swap_done=0.
  - On the edge where swap_done=1: swap_flag<=0, bus_own<=1 -> NEXT.
  - swap_flag is therefore low in the cycle the swap FSM returns to its start state, so no re-trigger.
- NEXT:
  - If counter_i==255 -> DONE. i is not incremented, so no wrap to 0.
  - Else counter_i<=counter_i+1, k advances -> RD_I.
- DONE: done=1 for exactly one cycle -> IDLE. counter_i and counter_j hold their final values.
- counter_i and counter_j stay stable for the whole REQ state.
- j=i is legal; the swap FSM handles the self-swap.
- swap_done arriving outside REQ is ignored.
- Iteration latency: 5 cycles + swap duration.
- 256 iterations per pass, no early exit.

Optional Feature:
- Macro: KSA_SWAP_TIMEOUT_EN.
- Defined:
  - A 6-bit watchdog counts cycles in REQ.
  - If it reaches 63 without swap_done: swap_flag<=0, bus_own<=1, go to state ERR.
  - ERR: output err (1 bit, added port) stays high, busy=1; exits only on reset.
  - The watchdog clears on every REQ entry.
- Undefined: no watchdog, no err port; REQ waits indefinitely.

Test Plan:
- Reset while in REQ (swap_flag=1) -> next cycle swap_flag=0, busy=0, counter_i=0, counter_j=0; a following start begins from i=0.
- Key 0x000249, S memory model init identity, swap model with 11-cycle swap_done response -> j sequence 0x00, 0x03, 0x4E, 0x4F for i=0..3 (i=3 reads swapped s[3]=1).
- Swap handshake: swap_done high one cycle -> swap_flag low the next cycle and never high again until the next REQ; exactly 256 rising edges of swap_flag per pass; done pulses once, 1 cycle.
- start pulsed at i=10 mid-pass and swap_done pulsed in IDLE -> no effect; after pass, full S compared against a golden RC4 KSA model for keys 0x000000, 0xFFFFFF, 0x1A2B3C.
- i boundary -> at i=255 NEXT goes to DONE; counter_i reads 255 after done; bus_own=0 only during REQ, wren=0 throughout.
- KSA_SWAP_TIMEOUT_EN defined, swap_done held 0 -> 63 cycles after REQ entry err=1, swap_flag=0; state holds until reset.

Source files
------------

// File: rtl/ksa_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// ksa_ctrl_fsm -- RC4 key-scheduling (KSA) loop controller.
//
// Walks i = 0..255 over the shared S working memory. For each i it reads s[i],
// accumulates j = j + s[i] + key[i mod KEY_LEN], hands (i, j) to the swap FSM
// and waits for the swap to complete. The done pulse hands off to the PRGA
// stage. Meant to run after the S-memory init pass (s[i] = i) has finished.
//
// Parameters:
//   KEY_LEN     key length in bytes (the key index counter is 2 bits, so <= 4)
//   KEY_W       secret key width in bits, must equal 8*KEY_LEN
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-high reset (aborts a pass immediately)
//   start       one-cycle pulse that begins a pass; only sampled in IDLE
//   secret_key  key; byte k = secret_key[KEY_W-1-8k -: 8] (byte 0 is the MSB)
//   s_q         S-memory read data (valid two cycles after s_addr changes)
//   s_addr      S-memory address while this block owns the bus
//   counter_i   current i, to the swap FSM
//   counter_j   current j, to the swap FSM
//   swap_flag   swap request to the swap FSM
//   swap_done   swap complete, from the swap FSM (ignored outside REQ)
//   bus_own     1 = top-level mux routes s_addr to memory, 0 = swap FSM owns it
//   wren        always 0; this block never writes
//   busy        high in every state except IDLE
//   done        one-cycle pulse when the pass completes
//   err         (only with KSA_SWAP_TIMEOUT_EN) swap watchdog tripped; sticky
//               until reset
//
// Optional feature, macro KSA_SWAP_TIMEOUT_EN: a 6-bit watchdog counts cycles
// spent in REQ. If it reaches 63 without swap_done the request is withdrawn and
// the block parks in ERR with err high until reset.
// -----------------------------------------------------------------------------
module ksa_ctrl_fsm #(
    parameter int KEY_LEN = 3,
    parameter int KEY_W   = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [KEY_W-1:0] secret_key,
    input  logic [7:0]       s_q,
    output logic [7:0]       s_addr,
    output logic [7:0]       counter_i,
    output logic [7:0]       counter_j,
    output logic             swap_flag,
    input  logic             swap_done,
    output logic             bus_own,
    output logic             wren,
    output logic             busy,
    output logic             done
`ifdef KSA_SWAP_TIMEOUT_EN
    ,
    output logic             err
`endif
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_I,
        S_WAIT,
        S_CAPT,
        S_CALC,
        S_REQ,
        S_NEXT,
        S_DONE,
        S_ERR
    } state_t;

    // Last value of the key byte index before it wraps back to 0.
    localparam logic [1:0] K_LAST = 2'(KEY_LEN - 1);

    state_t     state_reg, state_next;
    logic [7:0] i_reg, i_next;
    logic [7:0] j_reg, j_next;
    logic [1:0] k_reg, k_next;
    logic [7:0] s_i_reg, s_i_next;
    logic [7:0] s_addr_reg, s_addr_next;
    logic       swap_flag_reg, swap_flag_next;
    logic       bus_own_reg, bus_own_next;
    logic       busy_reg, busy_next;
    logic       done_reg, done_next;

`ifdef KSA_SWAP_TIMEOUT_EN
    // Watchdog trips on the cycle its count would reach 63.
    localparam logic [5:0] WD_TRIP = 6'd62;
    logic [5:0] wd_reg, wd_next;
    logic       err_reg, err_next;
`endif

    // Key bytes unpacked into a 4-entry table indexed directly by the 2-bit key
    // index counter k; k tracks i mod KEY_LEN so no divider is needed. Slots
    // beyond KEY_LEN are never selected and tie to zero.
    logic [7:0] key_byte [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_key
            if (gi < KEY_LEN) begin : g_used
                assign key_byte[gi] = secret_key[KEY_W-1-8*gi -: 8];
            end else begin : g_unused
                assign key_byte[gi] = 8'h00;
            end
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        i_next         = i_reg;
        j_next         = j_reg;
        k_next         = k_reg;
        s_i_next       = s_i_reg;
        s_addr_next    = s_addr_reg;
        swap_flag_next = swap_flag_reg;
        bus_own_next   = bus_own_reg;
        done_next      = 1'b0;
`ifdef KSA_SWAP_TIMEOUT_EN
        wd_next        = wd_reg;
        err_next       = err_reg;
`endif

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    i_next     = 8'd0;
                    j_next     = 8'd0;
                    k_next     = 2'd0;
                    state_next = S_RD_I;
                end
            end

            S_RD_I: begin
                s_addr_next  = i_reg;
                bus_own_next = 1'b1;
                state_next   = S_WAIT;
            end

            // Registered address plus synchronous RAM: one dead cycle before
            // s_q reflects s[i].
            S_WAIT: begin
                state_next = S_CAPT;
            end

            S_CAPT: begin
                s_i_next   = s_q;
                state_next = S_CALC;
            end

            // Request goes out together with the new j so the swap FSM never
            // sees a stale pair.
            S_CALC: begin
                j_next         = j_reg + s_i_reg + key_byte[k_reg];
                swap_flag_next = 1'b1;
                bus_own_next   = 1'b0;
                state_next     = S_REQ;
`ifdef KSA_SWAP_TIMEOUT_EN
                wd_next        = 6'd0;
`endif
            end

            // Dropping swap_flag on the swap_done edge means the flag is already
            // low when the swap FSM is back in its start state.
            S_REQ: begin
                if (swap_done) begin
                    swap_flag_next = 1'b0;
                    bus_own_next   = 1'b1;
                    state_next     = S_NEXT;
                end
`ifdef KSA_SWAP_TIMEOUT_EN
                else if (wd_reg == WD_TRIP) begin
                    wd_next        = wd_reg + 6'd1;
                    swap_flag_next = 1'b0;
                    bus_own_next   = 1'b1;
                    err_next       = 1'b1;
                    state_next     = S_ERR;
                end else begin
                    wd_next = wd_reg + 6'd1;
                end
`endif
            end

            // i stops at 255 rather than wrapping so it reads 255 after done.
            S_NEXT: begin
                if (i_reg == 8'hFF) begin
                    done_next  = 1'b1;
                    state_next = S_DONE;
                end else begin
                    i_next     = i_reg + 8'd1;
                    k_next     = (k_reg == K_LAST) ? 2'd0 : k_reg + 2'd1;
                    state_next = S_RD_I;
                end
            end

            S_DONE: begin
                state_next = S_IDLE;
            end

`ifdef KSA_SWAP_TIMEOUT_EN
            S_ERR: begin
                state_next = S_ERR;
            end
`endif

            default: begin
                state_next = S_IDLE;
            end
        endcase

        busy_next = (state_next != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            i_reg         <= 8'd0;
            j_reg         <= 8'd0;
            k_reg         <= 2'd0;
            s_i_reg       <= 8'd0;
            s_addr_reg    <= 8'd0;
            swap_flag_reg <= 1'b0;
            bus_own_reg   <= 1'b1;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
`ifdef KSA_SWAP_TIMEOUT_EN
            wd_reg        <= 6'd0;
            err_reg       <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            i_reg         <= i_next;
            j_reg         <= j_next;
            k_reg         <= k_next;
            s_i_reg       <= s_i_next;
            s_addr_reg    <= s_addr_next;
            swap_flag_reg <= swap_flag_next;
            bus_own_reg   <= bus_own_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
`ifdef KSA_SWAP_TIMEOUT_EN
            wd_reg        <= wd_next;
            err_reg       <= err_next;
`endif
        end
    end

    assign s_addr    = s_addr_reg;
    assign counter_i = i_reg;
    assign counter_j = j_reg;
    assign swap_flag = swap_flag_reg;
    assign bus_own   = bus_own_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign wren      = 1'b0;
`ifdef KSA_SWAP_TIMEOUT_EN
    assign err       = err_reg;
`endif

endmodule
